// File: rtl/wb_rr_arbiter.sv
// Two-master Wishbone round-robin arbiter with bus lock held for the owner's whole cyc
// and a watchdog that forces an error when the slave stops responding.
module wb_rr_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk,
    input  logic            wb_rst_n,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic [2:0]      m0_cti_i,
    input  logic [1:0]      m0_bte_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic [2:0]      m1_cti_i,
    input  logic [1:0]      m1_bte_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic [2:0]      s_cti_o,
    output logic [1:0]      s_bte_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i,
    output logic [1:0]      grant_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] WD_ONE   = CW'(1);

    // State encoding doubles as the one-hot grant vector.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } state_t;

    state_t        state;
    logic          last_owner;
    logic [CW-1:0] wd_cnt;

    logic g0, g1;
    logic own_cyc, own_stb, resp, timeout;

    assign g0      = (state == OWN0);
    assign g1      = (state == OWN1);
    assign grant_o = {g1, g0};

    assign own_cyc = (g0 & m0_cyc_i) | (g1 & m1_cyc_i);
    assign own_stb = (g0 & m0_cyc_i & m0_stb_i) | (g1 & m1_cyc_i & m1_stb_i);
    assign resp    = s_ack_i | s_err_i | s_rty_i;
    assign timeout = own_stb & (wd_cnt == WD_LIMIT);

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            wd_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_cyc_i && m1_cyc_i)
                        state <= last_owner ? OWN0 : OWN1;
                    else if (m0_cyc_i)
                        state <= OWN0;
                    else if (m1_cyc_i)
                        state <= OWN1;
                end
                OWN0: begin
                    if (!m0_cyc_i) begin
                        state      <= IDLE;
                        last_owner <= 1'b0;
                    end
                end
                OWN1: begin
                    if (!m1_cyc_i) begin
                        state      <= IDLE;
                        last_owner <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (!own_stb || resp || timeout)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + WD_ONE;
        end
    end

    always_comb begin
        s_adr_o = '0;
        s_dat_o = '0;
        s_sel_o = '0;
        s_we_o  = 1'b0;
        s_cti_o = '0;
        s_bte_o = '0;
        if (g0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = m0_sel_i;
            s_we_o  = m0_we_i;
            s_cti_o = m0_cti_i;
            s_bte_o = m0_bte_i;
        end else if (g1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = m1_sel_i;
            s_we_o  = m1_we_i;
            s_cti_o = m1_cti_i;
            s_bte_o = m1_bte_i;
        end
    end

    // The watchdog cycle hides the bus from the slave and swallows any late response.
    assign s_cyc_o = own_cyc & ~timeout;
    assign s_stb_o = own_stb & ~timeout;

    assign m0_ack_o = g0 & s_ack_i & ~timeout;
    assign m0_rty_o = g0 & s_rty_i & ~timeout;
    assign m0_err_o = g0 & (timeout | s_err_i);
    assign m1_ack_o = g1 & s_ack_i & ~timeout;
    assign m1_rty_o = g1 & s_rty_i & ~timeout;
    assign m1_err_o = g1 & (timeout | s_err_i);

    assign m0_dat_o = s_dat_i;
    assign m1_dat_o = s_dat_i;

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter: single master, round-robin, lock, watchdog, reset.
module tb_wb_rr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          wb_clk = 1'b0;
    logic          wb_rst_n;
    logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
    logic          m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
    logic [2:0]    m0_cti_i, m1_cti_i, s_cti_o;
    logic [1:0]    m0_bte_i, m1_bte_i, s_bte_o, grant_o;
    logic          m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i, s_rty_i;

    int n_cmp = 0;
    int n_err = 0;

    wb_rr_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(4)) dut (
        .wb_clk(wb_clk), .wb_rst_n(wb_rst_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o)
    );

    always #5 wb_clk = ~wb_clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then let outputs settle before driving/sampling.
    task automatic step();
        @(posedge wb_clk);
        #1;
    endtask

    initial begin
        wb_rst_n = 1'b0;
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m0_cti_i = '0; m0_bte_i = '0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        m1_cti_i = '0; m1_bte_i = '0;
        s_dat_i = '0; s_ack_i = 0; s_err_i = 0; s_rty_i = 0;

        // Reset: requests and slave responses must not leak through.
        step();
        m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
        #1;
        check("rst_grant", grant_o, 2'b00);
        check("rst_s_cyc", s_cyc_o, 0);
        check("rst_m0_ack", m0_ack_o, 0);
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        @(negedge wb_clk);
        wb_rst_n = 1'b1;

        // Single master read at 0x10.
        step();
        m0_adr_i = 32'h10; m0_sel_i = 4'hF; m0_cyc_i = 1; m0_stb_i = 1;
        #1;
        check("t1_grant_before", grant_o, 2'b00);
        step();
        check("t1_grant", grant_o, 2'b01);
        check("t1_s_cyc", s_cyc_o, 1);
        check("t1_s_stb", s_stb_o, 1);
        check("t1_s_adr", s_adr_o, 32'h10);
        s_ack_i = 1; s_dat_i = 32'hCAFEF00D;
        #1;
        check("t1_m0_ack", m0_ack_o, 1);
        check("t1_m0_dat", m0_dat_o, 32'hCAFEF00D);
        check("t1_m1_ack", m1_ack_o, 0);
        check("t1_m1_err", m1_err_o, 0);
        step();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        #1;
        check("t1_drop_s_cyc", s_cyc_o, 0);
        step();
        check("t1_idle", grant_o, 2'b00);

        // Fresh reset so master 0 wins the simultaneous request.
        #2 wb_rst_n = 1'b0;
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        step();
        m0_cyc_i = 1; m0_stb_i = 1;
        m1_cyc_i = 1; m1_stb_i = 1; m1_adr_i = 32'h44; m1_we_i = 1;
        m1_dat_i = 32'h12345678; m1_sel_i = 4'h3;
        step();
        check("t2_first", grant_o, 2'b01);
        s_ack_i = 1;
        #1;
        check("t2_m0_ack", m0_ack_o, 1);
        check("t2_m1_ack", m1_ack_o, 0);
        step();
        m0_cyc_i = 0; m0_stb_i = 0; s_ack_i = 0;
        step();
        check("t2_gap", grant_o, 2'b00);
        step();
        check("t2_second", grant_o, 2'b10);
        check("t2_s_adr", s_adr_o, 32'h44);
        check("t2_s_dat", s_dat_o, 32'h12345678);
        check("t2_s_we", s_we_o, 1);
        check("t2_s_sel", s_sel_o, 4'h3);
        step();
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        step();

        // Fairness: both keep requesting; owners alternate 0,1,0,1...
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        for (int i = 0; i < 8; i++) begin
            step();
            check($sformatf("t3_grant%0d", i), grant_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            s_ack_i = 1;
            #1;
            check($sformatf("t3_ack%0d", i), {m1_ack_o, m0_ack_o}, (i % 2 == 0) ? 2'b01 : 2'b10);
            step();
            s_ack_i = 0;
            if (i % 2 == 0) begin m0_cyc_i = 0; m0_stb_i = 0; end
            else            begin m1_cyc_i = 0; m1_stb_i = 0; end
            step();
            check($sformatf("t3_idle%0d", i), grant_o, 2'b00);
            m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        end

        // Lock: 4-beat incrementing burst by m0 while m1 waits.
        step();
        check("t4_grant", grant_o, 2'b01);
        for (int b = 0; b < 4; b++) begin
            m0_cti_i = (b == 3) ? 3'b111 : 3'b010;
            s_ack_i = 1;
            #1;
            check($sformatf("t4_ack%0d", b), {m1_ack_o, m0_ack_o}, 2'b01);
            check($sformatf("t4_cti%0d", b), s_cti_o, (b == 3) ? 3'b111 : 3'b010);
            check($sformatf("t4_lock%0d", b), grant_o, 2'b01);
            step();
        end
        m0_cyc_i = 0; m0_stb_i = 0; m0_cti_i = '0; s_ack_i = 0;
        #1;
        check("t4_still_m0", grant_o, 2'b01);
        step();
        check("t4_gap", grant_o, 2'b00);
        step();
        check("t4_m1", grant_o, 2'b10);

        // Watchdog (TIMEOUT=4): err in 5th and 10th stb cycles; late ack dropped.
        for (int c = 1; c <= 11; c++) begin
            s_ack_i = (c == 10);
            #1;
            check($sformatf("t5_err%0d", c), m1_err_o, (c == 5 || c == 10));
            check($sformatf("t5_stb%0d", c), s_stb_o, !(c == 5 || c == 10));
            if (c == 10) check("t5_ack_dropped", m1_ack_o, 0);
            if (c == 5)  check("t5_m0_err", m0_err_o, 0);
            if (c < 11) step();
        end
        s_ack_i = 0;
        check("t6_pre_cyc", s_cyc_o, 1);

        // Reset mid-transfer in OWN1, then simultaneous request after release.
        #2 wb_rst_n = 1'b0;
        #1;
        check("t6_grant", grant_o, 2'b00);
        check("t6_s_cyc", s_cyc_o, 0);
        s_ack_i = 1;
        #1;
        check("t6_m1_ack", m1_ack_o, 0);
        s_ack_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1;
        step();
        check("t6_held", grant_o, 2'b00);
        @(negedge wb_clk);
        wb_rst_n = 1'b1;
        step();
        check("t6_m0_wins", grant_o, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
